// File: rtl/ahb_decode_mux_n.sv
// AHB address decoder and response mux with an internal default slave and a
// per-port wait-state timeout that quarantines a hung slave until software clears it.
//
// state | meaning
// NONE  | no data phase pending; zero-wait OKAY
// SLAVE | data phase owned by port sel_q
// ERR1  | default-slave / timeout error, first cycle (HREADYS=0)
// ERR2  | error response, second cycle (HREADYS=1)
module ahb_decode_mux_n #(
  parameter int                   NPORTS  = 8,
  parameter int                   DWIDTH  = 32,
  parameter logic [NPORTS*32-1:0] BASE    = '0,
  parameter logic [NPORTS*5-1:0]  WIDTH   = '0,
  parameter logic [NPORTS-1:0]    ENABLE  = {NPORTS{1'b0}},
  parameter int                   TIMEOUT = 256
) (
  input  logic                     HCLK,
  input  logic                     HRESET,
  input  logic [31:0]              HADDRS,
  input  logic [1:0]               HTRANSS,
  input  logic [NPORTS-1:0]        HREADYOUTM,
  input  logic [NPORTS-1:0]        HRESPM,
  input  logic [NPORTS*DWIDTH-1:0] HRDATAM,
  input  logic                     TIMEOUT_CLR,
  output logic [NPORTS-1:0]        HSELM,
  output logic                     HREADYS,
  output logic                     HRESPS,
  output logic [DWIDTH-1:0]        HRDATAS,
  output logic                     TIMEOUT_IRQ,
  output logic [3:0]               TIMEOUT_PORT,
  output logic [NPORTS-1:0]        QUARANTINE
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {NONE, SLAVE, ERR1, ERR2} state_t;

  state_t              state_q, state_d;
  logic [3:0]          sel_q, sel_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [NPORTS-1:0]   quar_q, quar_d;
  logic                irq_q, irq_d;
  logic [3:0]          port_q, port_d;

  logic [3:0]          win;
  logic                any_hit;
  logic                rdy_sel, resp_sel, timeout;
  logic [DWIDTH-1:0]   rdata_sel;
  logic                htrans_unused;

  assign htrans_unused = HTRANSS[0];

  function automatic logic port_hit(input int k, input logic [31:0] addr);
    logic [31:0] mask;
    mask = 32'hFFFF_FFFF << WIDTH[k*5 +: 5];
    return ((addr ^ BASE[k*32 +: 32]) & mask) == 32'h0;
  endfunction

  // Scan high to low so the lowest matching index is the one left standing.
  always_comb begin
    win     = '0;
    any_hit = 1'b0;
    for (int k = NPORTS - 1; k >= 0; k--) begin
      if (ENABLE[k] && !quar_q[k] && port_hit(k, HADDRS)) begin
        win     = 4'(k);
        any_hit = 1'b1;
      end
    end
    HSELM = any_hit ? (NPORTS'(1) << win) : '0;
  end

  always_comb begin
    rdy_sel   = 1'b1;
    resp_sel  = 1'b0;
    rdata_sel = '0;
    for (int k = 0; k < NPORTS; k++) begin
      if (sel_q == 4'(k)) begin
        rdy_sel   = HREADYOUTM[k];
        resp_sel  = HRESPM[k];
        rdata_sel = HRDATAM[k*DWIDTH +: DWIDTH];
      end
    end
  end

  always_comb begin
    HREADYS = 1'b1;
    HRESPS  = 1'b0;
    HRDATAS = '0;
    case (state_q)
      SLAVE: begin
        HREADYS = rdy_sel;
        HRESPS  = resp_sel;
        HRDATAS = rdata_sel;
      end
      ERR1: begin
        HREADYS = 1'b0;
        HRESPS  = 1'b1;
      end
      ERR2:    HRESPS = 1'b1;
      default: ;
    endcase

    timeout = (TIMEOUT != 0) && (state_q == SLAVE) && !rdy_sel && (cnt_q == CNT_LAST);

    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    if (timeout) begin
      state_d = ERR1;
    end else if (state_q == ERR1) begin
      state_d = ERR2;
    end else if (HREADYS) begin
      if (HTRANSS[1] && any_hit) begin
        state_d = SLAVE;
        sel_d   = win;
        cnt_d   = '0;
      end else if (HTRANSS[1]) begin
        state_d = ERR1;
      end else begin
        state_d = NONE;
      end
    end else if (state_q == SLAVE && cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CW'(1);
    end

    // Clear first so a coinciding timeout still leaves its own flag set.
    quar_d = quar_q;
    irq_d  = irq_q;
    port_d = port_q;
    if (TIMEOUT_CLR) begin
      quar_d = '0;
      irq_d  = 1'b0;
    end
    if (timeout) begin
      quar_d = quar_d | (NPORTS'(1) << sel_q);
      irq_d  = 1'b1;
      port_d = sel_q;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q <= NONE;
      sel_q   <= '0;
      cnt_q   <= '0;
      quar_q  <= '0;
      irq_q   <= 1'b0;
      port_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      quar_q  <= quar_d;
      irq_q   <= irq_d;
      port_q  <= port_d;
    end
  end

  assign QUARANTINE   = quar_q;
  assign TIMEOUT_IRQ  = irq_q;
  assign TIMEOUT_PORT = port_q;

endmodule

// File: tb/tb_ahb_decode_mux_n.sv
// Bench for ahb_decode_mux_n: directed bus scenarios plus randomized traffic,
// all compared cycle by cycle against a transaction-level reference model.
module tb_ahb_decode_mux_n;

  localparam int NP   = 4;
  localparam int P_TO = 8;
  localparam logic [NP*32-1:0] P_BASE  = {32'h6000_0000, 32'h4000_0000, 32'h2000_0000, 32'h0000_0000};
  localparam logic [NP*5-1:0]  P_WIDTH = {5'd16, 5'd12, 5'd16, 5'd16};
  localparam logic [NP-1:0]    P_EN    = 4'b0111;

  int unsigned m_base  [NP] = '{32'h0000_0000, 32'h2000_0000, 32'h4000_0000, 32'h6000_0000};
  int          m_width [NP] = '{16, 16, 12, 16};
  bit          m_en    [NP] = '{1'b1, 1'b1, 1'b1, 1'b0};

  logic              HCLK = 1'b0;
  logic              HRESET = 1'b1;
  logic [31:0]       HADDRS = '0;
  logic [1:0]        HTRANSS = '0;
  logic [NP-1:0]     HREADYOUTM = '1;
  logic [NP-1:0]     HRESPM = '0;
  logic [31:0]       rd [NP];
  logic [NP*32-1:0]  HRDATAM;
  logic              TIMEOUT_CLR = 1'b0;
  logic [NP-1:0]     HSELM;
  logic              HREADYS, HRESPS, TIMEOUT_IRQ;
  logic [31:0]       HRDATAS;
  logic [3:0]        TIMEOUT_PORT;
  logic [NP-1:0]     QUARANTINE;

  assign HRDATAM = {rd[3], rd[2], rd[1], rd[0]};

  always #5 HCLK = ~HCLK;

  ahb_decode_mux_n #(
    .NPORTS(NP), .DWIDTH(32), .BASE(P_BASE), .WIDTH(P_WIDTH), .ENABLE(P_EN), .TIMEOUT(P_TO)
  ) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HADDRS(HADDRS), .HTRANSS(HTRANSS),
    .HREADYOUTM(HREADYOUTM), .HRESPM(HRESPM), .HRDATAM(HRDATAM), .TIMEOUT_CLR(TIMEOUT_CLR),
    .HSELM(HSELM), .HREADYS(HREADYS), .HRESPS(HRESPS), .HRDATAS(HRDATAS),
    .TIMEOUT_IRQ(TIMEOUT_IRQ), .TIMEOUT_PORT(TIMEOUT_PORT), .QUARANTINE(QUARANTINE)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model: which port owns the data phase (-1 = none), how many
  // error cycles remain, and how many wait cycles the current transfer has seen.
  int       cur = -1;
  int       err_left = 0;
  int       waited = 0;
  bit [3:0] mq = '0;
  bit       mirq = 1'b0;
  int       mport = 0;

  function automatic int m_decode(input logic [31:0] a);
    for (int k = 0; k < NP; k++)
      if (m_en[k] && !mq[k] && ((a >> m_width[k]) == (m_base[k] >> m_width[k]))) return k;
    return -1;
  endfunction

  task automatic tick();
    int w;
    logic er, ep;
    logic [31:0] ed;
    bit to;
    #1;
    w  = m_decode(HADDRS);
    er = 1'b1; ep = 1'b0; ed = '0;
    if (err_left == 2) begin er = 1'b0; ep = 1'b1; end
    else if (err_left == 1) ep = 1'b1;
    else if (cur >= 0) begin er = HREADYOUTM[cur]; ep = HRESPM[cur]; ed = rd[cur]; end
    chk("hselm", HSELM, (w >= 0) ? (64'd1 << w) : 64'd0);
    chk("hreadys", HREADYS, er);
    chk("hresps", HRESPS, ep);
    chk("hrdatas", HRDATAS, ed);
    chk("quarantine", QUARANTINE, mq);
    chk("irq", TIMEOUT_IRQ, mirq);
    chk("tport", TIMEOUT_PORT, mport);
    @(posedge HCLK);
    if (HRESET) begin
      cur = -1; err_left = 0; waited = 0; mq = '0; mirq = 1'b0; mport = 0;
    end else begin
      to = (err_left == 0) && (cur >= 0) && !HREADYOUTM[cur] && (waited == P_TO - 1);
      if (TIMEOUT_CLR) begin mq = '0; mirq = 1'b0; end
      if (to) begin mq[cur] = 1'b1; mirq = 1'b1; mport = cur; end
      if (to) begin
        err_left = 2; cur = -1;
      end else if (err_left == 2) begin
        err_left = 1;
      end else if (er) begin
        err_left = 0;
        if (HTRANSS[1] && w >= 0) begin cur = w; waited = 0; end
        else if (HTRANSS[1]) begin cur = -1; err_left = 2; end
        else cur = -1;
      end else begin
        waited++;
      end
    end
    @(negedge HCLK);
  endtask

  int stuck;

  initial begin
    for (int k = 0; k < NP; k++) rd[k] = 32'h0;
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    HRESET = 1'b0;
    #1;
    chk("rst_ready", HREADYS, 1'b1);
    chk("rst_resp", HRESPS, 1'b0);
    chk("rst_quar", QUARANTINE, 4'b0000);
    tick();

    // Decode to slave 1
    rd[1] = 32'hA5A5_5A5A;
    HADDRS = 32'h2000_0010; HTRANSS = 2'b10;
    #1 chk("dec_hsel", HSELM, 4'b0010);
    tick();
    HADDRS = 32'h0; HTRANSS = 2'b00;
    #1 chk("dec_data", HRDATAS, 32'hA5A5_5A5A);
    chk("dec_resp", HRESPS, 1'b0);
    tick();

    // Default slave, then IDLE to the same unmapped address
    HADDRS = 32'h8000_0000; HTRANSS = 2'b10;
    #1 chk("dflt_hsel", HSELM, 4'b0000);
    tick();
    HTRANSS = 2'b00;
    #1 chk("dflt_e1_rdy", HREADYS, 1'b0);
    chk("dflt_e1_resp", HRESPS, 1'b1);
    tick();
    #1 chk("dflt_e2_rdy", HREADYS, 1'b1);
    chk("dflt_e2_resp", HRESPS, 1'b1);
    tick();
    #1 chk("idle_rdy", HREADYS, 1'b1);
    chk("idle_resp", HRESPS, 1'b0);
    tick();

    // Timeout on slave 2
    HADDRS = 32'h4000_0000; HTRANSS = 2'b10;
    tick();
    HADDRS = 32'h0; HTRANSS = 2'b00; HREADYOUTM = 4'b1011;
    for (int i = 0; i < P_TO; i++) begin
      #1 chk("to_wait", HREADYS, 1'b0);
      tick();
    end
    HREADYOUTM = 4'b1111;
    #1 chk("to_e1_rdy", HREADYS, 1'b0);
    chk("to_e1_resp", HRESPS, 1'b1);
    chk("to_quar", QUARANTINE, 4'b0100);
    chk("to_irq", TIMEOUT_IRQ, 1'b1);
    chk("to_port", TIMEOUT_PORT, 4'd2);
    tick();
    HADDRS = 32'h4000_0000; HTRANSS = 2'b10;
    #1 chk("to_e2_rdy", HREADYS, 1'b1);
    chk("to_e2_resp", HRESPS, 1'b1);
    chk("quar_hsel", HSELM, 4'b0000);
    tick();
    HTRANSS = 2'b00;
    #1 chk("quar_e1_rdy", HREADYS, 1'b0);
    chk("quar_e1_resp", HRESPS, 1'b1);
    tick();
    tick();

    // Clear coinciding with a slave 1 timeout
    HADDRS = 32'h2000_0000; HTRANSS = 2'b10;
    tick();
    HTRANSS = 2'b00; HREADYOUTM = 4'b1101;
    repeat (P_TO - 1) tick();
    TIMEOUT_CLR = 1'b1;
    tick();
    TIMEOUT_CLR = 1'b0; HREADYOUTM = 4'b1111;
    #1 chk("race_quar", QUARANTINE, 4'b0010);
    chk("race_irq", TIMEOUT_IRQ, 1'b1);
    chk("race_port", TIMEOUT_PORT, 4'd1);
    tick();
    tick();
    TIMEOUT_CLR = 1'b1;
    tick();
    TIMEOUT_CLR = 1'b0;
    #1 chk("clr_quar", QUARANTINE, 4'b0000);
    chk("clr_irq", TIMEOUT_IRQ, 1'b0);
    tick();

    // Reset during a slave 0 wait state; next transfer must get a full budget
    HADDRS = 32'h0000_0100; HTRANSS = 2'b10;
    tick();
    HTRANSS = 2'b00; HREADYOUTM = 4'b1110;
    repeat (3) tick();
    HRESET = 1'b1;
    tick();
    HRESET = 1'b0;
    #1 chk("mrst_rdy", HREADYS, 1'b1);
    chk("mrst_resp", HRESPS, 1'b0);
    tick();
    HTRANSS = 2'b10;
    tick();
    HTRANSS = 2'b00;
    for (int i = 0; i < P_TO; i++) begin
      #1 chk("mrst_wait", HREADYS, 1'b0);
      chk("mrst_noquar", QUARANTINE, 4'b0000);
      tick();
    end
    HREADYOUTM = 4'b1111;
    #1 chk("mrst_quar", QUARANTINE, 4'b0001);
    tick();
    tick();
    TIMEOUT_CLR = 1'b1;
    tick();
    TIMEOUT_CLR = 1'b0;

    // Back-to-back pipelined transfers 0, 1, 0
    rd[0] = 32'h1111_0000; rd[1] = 32'h2222_0001;
    HADDRS = 32'h0000_0010; HTRANSS = 2'b10;
    tick();
    HADDRS = 32'h2000_0020;
    #1 chk("pipe_p0", HRDATAS, 32'h1111_0000);
    tick();
    HADDRS = 32'h0000_0030;
    #1 chk("pipe_p1", HRDATAS, 32'h2222_0001);
    tick();
    HTRANSS = 2'b00;
    #1 chk("pipe_p0b", HRDATAS, 32'h1111_0000);
    chk("pipe_rdy", HREADYS, 1'b1);
    tick();

    // Randomized traffic
    stuck = 4;
    for (int c = 0; c < 3000; c++) begin
      if (c % 64 == 0) stuck = $urandom_range(0, 5);
      case ($urandom_range(0, 5))
        0: HADDRS = 32'h0000_0000 | 32'($urandom_range(0, 16'hFFFF));
        1: HADDRS = 32'h2000_0000 | 32'($urandom_range(0, 16'hFFFF));
        2: HADDRS = 32'h4000_0000 | 32'($urandom_range(0, 12'hFFF));
        3: HADDRS = 32'h6000_0000 | 32'($urandom_range(0, 16'hFFFF));
        4: HADDRS = 32'h8000_0000 | 32'($urandom_range(0, 16'hFFFF));
        default: HADDRS = $urandom;
      endcase
      HTRANSS    = 2'($urandom_range(0, 3));
      HREADYOUTM = 4'($urandom) | 4'($urandom);
      if (stuck < NP) HREADYOUTM[stuck] = 1'b0;
      HRESPM     = 4'($urandom) & 4'($urandom) & 4'($urandom);
      for (int k = 0; k < NP; k++) rd[k] = $urandom;
      TIMEOUT_CLR = ($urandom_range(0, 39) == 0);
      HRESET      = ($urandom_range(0, 299) == 0);
      tick();
    end
    HRESET = 1'b0; TIMEOUT_CLR = 1'b0; HTRANSS = 2'b00;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
